data_memory_responder: RTL and testbench

Multi-cycle data-memory responder serving the MEM stage's load/store requests. It accepts one request at a time (mem_read or mem_write with address and write data), inserts a configurable number of wait states, then performs the access and returns a one-cycle ready pulse with read data or an error flag. It replaces the zero-latency combinational data memory, so the pipeline can be tested against realistic memory latency and stall on busy.

---
 rtl/data_memory_responder.sv | 135 +++++++++++++
 tb/tb_data_memory_responder.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/data_memory_responder.sv
// Multi-cycle word-addressed data memory for the MEM stage: one request at a time,
// WAIT_STATES wait cycles, then a one-cycle ready pulse with read data or an error flag.
module data_memory_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic        busy,
  output logic        addr_error,
  output logic [1:0]  dbg_state
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  // Handshake: a request (mem_read|mem_write) is taken only while busy=0; the
  // requester holds it until the single-cycle ready pulse, which is qualified by addr_error.

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, wdata_q;
  logic        rd_q, wr_q;
  logic [31:0] read_data_q;
  logic        ready_q, busy_q, err_q;
  logic [31:0] mem_q [DEPTH_WORDS];

  logic          accept;
  logic          enter_resp;
  logic [31:0]   src_addr;
  logic          src_rd, src_wr, src_err;
  logic [AW-1:0] src_idx;
  logic          do_write;

  function automatic logic req_err(input logic [31:0] a, input logic rd, input logic wr);
    return (a[1:0] != 2'b00) || (a[31:AW+2] != '0) || (rd && wr);
  endfunction

  assign accept = (state_q == S_IDLE) && (mem_read || mem_write);

  // With zero wait states RESP is entered straight from IDLE, so the live inputs
  // describe the access; otherwise the latched request does.
  always_comb begin
    src_addr = addr_q;
    src_rd   = rd_q;
    src_wr   = wr_q;
    if (state_q == S_IDLE) begin
      src_addr = address;
      src_rd   = mem_read;
      src_wr   = mem_write;
    end
  end

  assign src_err = req_err(src_addr, src_rd, src_wr);
  assign src_idx = src_addr[AW+1:2];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (WS == 4'd0) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = WS;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign enter_resp = (state_d == S_RESP);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      read_data_q <= 32'd0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        addr_q  <= address;
        wdata_q <= write_data;
        rd_q    <= mem_read;
        wr_q    <= mem_write;
      end
      ready_q <= enter_resp;
      busy_q  <= (state_d != S_IDLE);
      err_q   <= enter_resp && src_err;
      if (enter_resp && src_rd && !src_wr && !src_err) begin
        read_data_q <= mem_q[src_idx];
      end
    end
  end

  // Stores commit on the edge that ends RESP; a reset on that edge drops them.
  assign do_write = (state_q == S_RESP) && wr_q && !rd_q && !err_q && !reset;

  always_ff @(posedge clk) begin
    if (do_write) mem_q[addr_q[AW+1:2]] <= wdata_q;
  end

  assign read_data  = read_data_q;
  assign ready      = ready_q;
  assign busy       = busy_q;
  assign addr_error = err_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed bench: instance 0 runs with two wait states, instance 1 with none.
module tb_data_memory_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        rd_s   [2];
  logic        wr_s   [2];
  logic [31:0] addr_s [2];
  logic [31:0] wd_s   [2];
  logic [31:0] rdata_s[2];
  logic        ready_s[2];
  logic        busy_s [2];
  logic        err_s  [2];
  logic [1:0]  st_s   [2];

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  data_memory_responder #(.DEPTH_WORDS(256), .WAIT_STATES(2)) u_ws2 (
    .clk(clk), .reset(reset), .mem_read(rd_s[0]), .mem_write(wr_s[0]),
    .address(addr_s[0]), .write_data(wd_s[0]), .read_data(rdata_s[0]),
    .ready(ready_s[0]), .busy(busy_s[0]), .addr_error(err_s[0]), .dbg_state(st_s[0])
  );

  data_memory_responder #(.DEPTH_WORDS(256), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .reset(reset), .mem_read(rd_s[1]), .mem_write(wr_s[1]),
    .address(addr_s[1]), .write_data(wd_s[1]), .read_data(rdata_s[1]),
    .ready(ready_s[1]), .busy(busy_s[1]), .addr_error(err_s[1]), .dbg_state(st_s[1])
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request, hold it until ready, then confirm the pulse lasted one cycle.
  task automatic access(input int s, input string tag, input logic rd, input logic wr,
                        input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rdata, output logic err, output int lat);
    logic seen;
    @(negedge clk);
    rd_s[s] = rd; wr_s[s] = wr; addr_s[s] = a; wd_s[s] = d;
    lat = 0; seen = 1'b0; rdata = '0; err = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      lat++;
      if (ready_s[s]) seen = 1'b1;
    end
    if (!seen) check_eq({tag, "_timeout"}, 32'd0, 32'd1);
    rdata = rdata_s[s];
    err   = err_s[s];
    rd_s[s] = 1'b0; wr_s[s] = 1'b0;
    @(negedge clk);
    check_eq({tag, "_ready_drop"}, 32'(ready_s[s]), 32'd0);
    check_eq({tag, "_busy_drop"}, 32'(busy_s[s]), 32'd0);
  endtask

  logic [31:0] rdata;
  logic        err;
  int          lat;
  int          ready_cnt;

  initial begin
    reset = 1'b1;
    for (int s = 0; s < 2; s++) begin
      rd_s[s] = 1'b0; wr_s[s] = 1'b0; addr_s[s] = '0; wd_s[s] = '0;
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;

    check_eq("rst_rdata", rdata_s[0], 32'd0);
    check_eq("rst_ready", 32'(ready_s[0]), 32'd0);
    check_eq("rst_busy", 32'(busy_s[0]), 32'd0);
    check_eq("rst_err", 32'(err_s[0]), 32'd0);
    check_eq("rst_state", 32'(st_s[0]), 32'd0);

    access(0, "st10", 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, rdata, err, lat);
    check_eq("st10_lat", 32'(lat), 32'd3);
    check_eq("st10_err", 32'(err), 32'd0);

    access(0, "ld10", 1'b1, 1'b0, 32'h10, 32'h0, rdata, err, lat);
    check_eq("ld10_lat", 32'(lat), 32'd3);
    check_eq("ld10_err", 32'(err), 32'd0);
    check_eq("ld10_data", rdata, 32'hDEADBEEF);

    // Preload word 0 and word 8 so that the no-write cases can be observed.
    access(0, "st0", 1'b0, 1'b1, 32'h0, 32'h11111111, rdata, err, lat);
    access(0, "st20", 1'b0, 1'b1, 32'h20, 32'hCAFEF00D, rdata, err, lat);
    access(0, "ld0", 1'b1, 1'b0, 32'h0, 32'h0, rdata, err, lat);
    check_eq("ld0_data", rdata, 32'h11111111);

    access(0, "mis", 1'b1, 1'b0, 32'h13, 32'h0, rdata, err, lat);
    check_eq("mis_err", 32'(err), 32'd1);
    check_eq("mis_data_held", rdata, 32'h11111111);
    access(0, "ld10b", 1'b1, 1'b0, 32'h10, 32'h0, rdata, err, lat);
    check_eq("ld10b_data", rdata, 32'hDEADBEEF);

    access(0, "oor", 1'b0, 1'b1, 32'h400, 32'h22222222, rdata, err, lat);
    check_eq("oor_err", 32'(err), 32'd1);
    access(0, "ld0b", 1'b1, 1'b0, 32'h0, 32'h0, rdata, err, lat);
    check_eq("ld0b_data", rdata, 32'h11111111);
    check_eq("ld0b_err", 32'(err), 32'd0);

    access(0, "both", 1'b1, 1'b1, 32'h0, 32'h33333333, rdata, err, lat);
    check_eq("both_err", 32'(err), 32'd1);
    access(0, "ld0c", 1'b1, 1'b0, 32'h0, 32'h0, rdata, err, lat);
    check_eq("ld0c_data", rdata, 32'h11111111);

    // Reset during WAIT discards the pending store.
    @(negedge clk);
    wr_s[0] = 1'b1; addr_s[0] = 32'h20; wd_s[0] = 32'h12345678;
    @(negedge clk);
    check_eq("abort_busy_wait", 32'(busy_s[0]), 32'd1);
    check_eq("abort_state_wait", 32'(st_s[0]), 32'd1);
    reset = 1'b1;
    wr_s[0] = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    check_eq("abort_busy", 32'(busy_s[0]), 32'd0);
    check_eq("abort_rdata", rdata_s[0], 32'd0);
    ready_cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (ready_s[0]) ready_cnt++;
    end
    check_eq("abort_no_ready", 32'(ready_cnt), 32'd0);
    access(0, "ld20", 1'b1, 1'b0, 32'h20, 32'h0, rdata, err, lat);
    check_eq("ld20_data", rdata, 32'hCAFEF00D);

    // Zero wait states: held load request gives ready every second cycle.
    access(1, "b_st10", 1'b0, 1'b1, 32'h10, 32'h5A5A5A5A, rdata, err, lat);
    check_eq("b_st10_lat", 32'(lat), 32'd1);
    check_eq("b_st10_err", 32'(err), 32'd0);
    @(negedge clk);
    rd_s[1] = 1'b1; addr_s[1] = 32'h10;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq($sformatf("b2b_ready%0d", i), 32'(ready_s[1]), (i % 2 == 0) ? 32'd1 : 32'd0);
      check_eq($sformatf("b2b_busy%0d", i), 32'(busy_s[1]), (i % 2 == 0) ? 32'd1 : 32'd0);
      if (i % 2 == 0) check_eq($sformatf("b2b_data%0d", i), rdata_s[1], 32'h5A5A5A5A);
    end
    rd_s[1] = 1'b0;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
